// File: rtl/matrix_rx_loader_if.sv
// Bus between the UART byte source / calculation core and matrix_rx_loader.
// The master side drives received bytes, control pulses and read addresses;
// the slave side (the loader) returns read data and status.
interface matrix_rx_loader_if #(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned SLOTS  = 2
);
    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [7:0]        rx_data;
    logic              rx_done;
    logic              clear;
    logic              gen_start;
    logic [3:0]        gen_m;
    logic [3:0]        gen_n;
    logic [SLOT_W-1:0] rd_slot;
    logic [3:0]        rd_row;
    logic [3:0]        rd_col;
    logic [ELEM_W-1:0] rd_data;
    logic [3:0]        rd_m;
    logic [3:0]        rd_n;
    logic [SLOTS-1:0]  slot_valid;
    logic              load_done;
    logic [SLOT_W-1:0] load_slot;
    logic              clamped;
    logic              busy;
    logic              err;
    logic [2:0]        state;

    modport master (
        output rx_data, rx_done, clear, gen_start, gen_m, gen_n,
               rd_slot, rd_row, rd_col,
        input  rd_data, rd_m, rd_n, slot_valid, load_done, load_slot,
               clamped, busy, err, state
    );

    modport slave (
        input  rx_data, rx_done, clear, gen_start, gen_m, gen_n,
               rd_slot, rd_row, rd_col,
        output rd_data, rd_m, rd_n, slot_valid, load_done, load_slot,
               clamped, busy, err, state
    );
endinterface

// File: rtl/matrix_rx_loader.sv
// Matrix input loader: parses "m, n, elements..." from the UART byte stream
// into a multi-slot matrix buffer with a registered random-access read port.
// Optional random-generation mode (GEN state + LFSR) is compiled in when
// MATRIX_RX_RANDGEN_EN is defined.
module matrix_rx_loader #(
    parameter int unsigned MAX_DIM  = 5,
    parameter int unsigned ELEM_W   = 8,
    parameter int unsigned ELEM_MAX = 9,
    parameter int unsigned SLOTS    = 2
) (
    input logic               clk,
    input logic               rst,
    matrix_rx_loader_if.slave bus
);
    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned CELLS  = SLOTS * MAX_DIM * MAX_DIM;
    localparam int unsigned IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_N = 3'd1,
        LOAD   = 3'd2,
        GEN    = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t            state_q;
    logic [3:0]        m_q, n_q, row_q, col_q;
    logic [SLOT_W-1:0] wr_ptr_q, load_slot_q;
    logic [SLOTS-1:0]  slot_valid_q;
    logic              load_done_q, clamped_q, err_q;
    logic [3:0]        dim_m [SLOTS];
    logic [3:0]        dim_n [SLOTS];
    logic [ELEM_W-1:0] mem [CELLS];
    logic [ELEM_W-1:0] rd_data_q;
    logic [3:0]        rd_m_q, rd_n_q;

`ifdef MATRIX_RX_RANDGEN_EN
    logic [7:0]        lfsr_q;
`endif

    logic              step_en, last_cell, elem_clamp;
    logic              rd_slot_ok, rd_hit;
    logic [ELEM_W-1:0] wr_val;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    function automatic logic dim_ok(input logic [7:0] d);
        return (d >= 8'd1) && (32'(d) <= MAX_DIM);
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input int unsigned s,
                                                  input int unsigned r,
                                                  input int unsigned c);
        int unsigned lin;
        lin = (s * MAX_DIM + r) * MAX_DIM + c;
        return IDX_W'(lin);
    endfunction

    // Element write strobe/value and read-port address decode
    always_comb begin
        step_en = 1'b0;
        if (!bus.clear) begin
            if (state_q == LOAD && bus.rx_done) step_en = 1'b1;
`ifdef MATRIX_RX_RANDGEN_EN
            if (state_q == GEN) step_en = 1'b1;
`endif
        end
        last_cell  = (row_q == m_q - 4'd1) && (col_q == n_q - 4'd1);
        elem_clamp = 32'(bus.rx_data) > ELEM_MAX;
        wr_val     = elem_clamp ? '0 : ELEM_W'(bus.rx_data);
`ifdef MATRIX_RX_RANDGEN_EN
        if (state_q == GEN) begin
            wr_val     = ELEM_W'(32'(lfsr_q) % (ELEM_MAX + 1));
            elem_clamp = 1'b0;
        end
`endif
        wr_idx     = cell_idx(32'(wr_ptr_q), 32'(row_q), 32'(col_q));
        rd_idx     = cell_idx(32'(bus.rd_slot), 32'(bus.rd_row), 32'(bus.rd_col));
        rd_slot_ok = (32'(bus.rd_slot) < SLOTS) && slot_valid_q[bus.rd_slot];
        rd_hit     = rd_slot_ok && (bus.rd_row < dim_m[bus.rd_slot])
                                && (bus.rd_col < dim_n[bus.rd_slot]);
    end

    // Element storage write port (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (step_en) mem[wr_idx] <= wr_val;
    end

    // Registered read port; a same-cycle write to the same cell returns old data
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_m_q    <= '0;
            rd_n_q    <= '0;
        end else begin
            rd_data_q <= rd_hit ? mem[rd_idx] : '0;
            rd_m_q    <= rd_slot_ok ? dim_m[bus.rd_slot] : '0;
            rd_n_q    <= rd_slot_ok ? dim_n[bus.rd_slot] : '0;
        end
    end

    // Load FSM: dimension parsing, element indexing, slot bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            m_q          <= '0;
            n_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            wr_ptr_q     <= '0;
            load_slot_q  <= '0;
            slot_valid_q <= '0;
            load_done_q  <= 1'b0;
            clamped_q    <= 1'b0;
            err_q        <= 1'b0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                dim_m[i] <= '0;
                dim_n[i] <= '0;
            end
        end else begin
            load_done_q <= 1'b0;
            if (bus.clear) begin
                state_q      <= IDLE;
                slot_valid_q <= '0;
                wr_ptr_q     <= '0;
                err_q        <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
`ifdef MATRIX_RX_RANDGEN_EN
                        if (bus.gen_start) begin
                            if (dim_ok({4'd0, bus.gen_m}) && dim_ok({4'd0, bus.gen_n})) begin
                                m_q                    <= bus.gen_m;
                                n_q                    <= bus.gen_n;
                                row_q                  <= '0;
                                col_q                  <= '0;
                                clamped_q              <= 1'b0;
                                slot_valid_q[wr_ptr_q] <= 1'b0;
                                state_q                <= GEN;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ERR;
                            end
                        end else
`endif
                        if (bus.rx_done) begin
                            if (dim_ok(bus.rx_data)) begin
                                m_q     <= bus.rx_data[3:0];
                                state_q <= WAIT_N;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ERR;
                            end
                        end
                    end
                    WAIT_N: begin
                        if (bus.rx_done) begin
                            if (dim_ok(bus.rx_data)) begin
                                n_q                    <= bus.rx_data[3:0];
                                row_q                  <= '0;
                                col_q                  <= '0;
                                clamped_q              <= 1'b0;
                                slot_valid_q[wr_ptr_q] <= 1'b0;
                                state_q                <= LOAD;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ERR;
                            end
                        end
                    end
                    LOAD, GEN, ERR: ;
                    default: state_q <= IDLE;
                endcase

                // LOAD and GEN share element indexing and completion
                if (step_en) begin
                    if (elem_clamp) clamped_q <= 1'b1;
                    if (last_cell) begin
                        dim_m[wr_ptr_q]        <= m_q;
                        dim_n[wr_ptr_q]        <= n_q;
                        slot_valid_q[wr_ptr_q] <= 1'b1;
                        load_done_q            <= 1'b1;
                        load_slot_q            <= wr_ptr_q;
                        wr_ptr_q               <= (32'(wr_ptr_q) == SLOTS - 1) ? '0 : wr_ptr_q + 1'b1;
                        row_q                  <= '0;
                        col_q                  <= '0;
                        state_q                <= IDLE;
                    end else if (col_q == n_q - 4'd1) begin
                        col_q <= '0;
                        row_q <= row_q + 4'd1;
                    end else begin
                        col_q <= col_q + 4'd1;
                    end
                end
            end
        end
    end

`ifdef MATRIX_RX_RANDGEN_EN
    // Fibonacci LFSR, taps 8,6,5,4, stepping on every GEN cycle
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 8'h01;
        else if (state_q == GEN) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
`else
    logic unused_gen;
    assign unused_gen = ^{bus.gen_start, bus.gen_m, bus.gen_n};
`endif

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_m       = rd_m_q;
    assign bus.rd_n       = rd_n_q;
    assign bus.slot_valid = slot_valid_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_slot  = load_slot_q;
    assign bus.clamped    = clamped_q;
    assign bus.err        = err_q;
    assign bus.busy       = (state_q == WAIT_N) || (state_q == LOAD) || (state_q == GEN);
    assign bus.state      = state_q;
endmodule

// File: tb/tb_matrix_rx_loader.sv
// Directed self-checking bench for matrix_rx_loader (default parameters).
// Random-generation checks are included when MATRIX_RX_RANDGEN_EN is defined.
module tb_matrix_rx_loader;
    localparam int unsigned MAX_DIM  = 5;
    localparam int unsigned ELEM_W   = 8;
    localparam int unsigned ELEM_MAX = 9;
    localparam int unsigned SLOTS    = 2;
    localparam int unsigned SLOT_W   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    matrix_rx_loader_if #(.ELEM_W(ELEM_W), .SLOTS(SLOTS)) bus ();

    matrix_rx_loader #(
        .MAX_DIM (MAX_DIM),
        .ELEM_W  (ELEM_W),
        .ELEM_MAX(ELEM_MAX),
        .SLOTS   (SLOTS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one byte for exactly one cycle; consecutive calls are back-to-back
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
    endtask

    task automatic end_bytes();
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic rd(input int s, input int r, input int c);
        @(negedge clk);
        bus.rd_slot = SLOT_W'(s);
        bus.rd_row  = 4'(r);
        bus.rd_col  = 4'(c);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int busy_cnt;
        logic [7:0] lf;

        bus.rx_data = '0;  bus.rx_done = 1'b0; bus.clear = 1'b0;
        bus.gen_start = 1'b0; bus.gen_m = '0; bus.gen_n = '0;
        bus.rd_slot = '0;  bus.rd_row = '0;   bus.rd_col = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_state", 32'(bus.state), 0);
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_rd_m", 32'(bus.rd_m), 0);
        check("rst_slot_valid", 32'(bus.slot_valid), 0);
        check("rst_load_done", 32'(bus.load_done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_clamped", 32'(bus.clamped), 0);

        // 2x3 load, bytes back-to-back -> slot 0
        send_byte(8'd2);
        send_byte(8'd3);
        check("wait_n_state", 32'(bus.state), 1);
        send_byte(8'd1);
        check("load_state", 32'(bus.state), 2);
        check("load_busy", 32'(bus.busy), 1);
        send_byte(8'd2); send_byte(8'd3); send_byte(8'd4);
        send_byte(8'd5); send_byte(8'd6);
        end_bytes();
        check("l1_done", 32'(bus.load_done), 1);
        check("l1_slot", 32'(bus.load_slot), 0);
        check("l1_valid", 32'(bus.slot_valid), 2'b01);
        check("l1_idle", 32'(bus.state), 0);
        @(negedge clk);
        check("l1_done_pulse", 32'(bus.load_done), 0);
        rd(0, 1, 2);
        check("l1_rd_12", 32'(bus.rd_data), 6);
        check("l1_rd_m", 32'(bus.rd_m), 2);
        check("l1_rd_n", 32'(bus.rd_n), 3);
        rd(0, 0, 0);
        check("l1_rd_00", 32'(bus.rd_data), 1);
        rd(0, 2, 0);
        check("l1_rd_row_oob", 32'(bus.rd_data), 0);
        rd(0, 0, 3);
        check("l1_rd_col_oob", 32'(bus.rd_data), 0);

        // 1x2 load -> slot 1
        send_byte(8'd1); send_byte(8'd2); send_byte(8'd7); send_byte(8'd8);
        end_bytes();
        check("l2_slot", 32'(bus.load_slot), 1);
        check("l2_valid", 32'(bus.slot_valid), 2'b11);

        // 2x1 load overwrites slot 0; its valid bit drops once n is accepted
        send_byte(8'd2); send_byte(8'd1);
        send_byte(8'd4);
        check("l3_valid_drop", 32'(bus.slot_valid), 2'b10);
        send_byte(8'd5);
        end_bytes();
        check("l3_slot", 32'(bus.load_slot), 0);
        check("l3_valid", 32'(bus.slot_valid), 2'b11);
        rd(0, 1, 0);
        check("l3_rd_10", 32'(bus.rd_data), 5);
        check("l3_rd_m", 32'(bus.rd_m), 2);
        check("l3_rd_n", 32'(bus.rd_n), 1);
        rd(1, 0, 1);
        check("l3_slot1_01", 32'(bus.rd_data), 8);
        rd(1, 0, 0);
        check("l3_slot1_00", 32'(bus.rd_data), 7);

        // Out-of-range element is stored as 0 and flagged -> slot 1
        send_byte(8'd1); send_byte(8'd1); send_byte(8'd12);
        end_bytes();
        check("clamp_slot", 32'(bus.load_slot), 1);
        check("clamp_flag", 32'(bus.clamped), 1);
        rd(1, 0, 0);
        check("clamp_rd", 32'(bus.rd_data), 0);
        check("clamp_rd_m", 32'(bus.rd_m), 1);
        // ELEM_MAX itself is legal; flag clears on the next load -> slot 0
        send_byte(8'd1); send_byte(8'd1); send_byte(8'd9);
        end_bytes();
        check("clamp_cleared", 32'(bus.clamped), 0);
        check("max_slot", 32'(bus.load_slot), 0);
        rd(0, 0, 0);
        check("max_rd", 32'(bus.rd_data), 9);

        // Dimension error is sticky, ignores bytes, exits only on clear
        send_byte(8'd7);
        end_bytes();
        check("err7_flag", 32'(bus.err), 1);
        check("err7_state", 32'(bus.state), 4);
        check("err7_busy", 32'(bus.busy), 0);
        send_byte(8'd2); send_byte(8'd3);
        end_bytes();
        check("err_ignore_state", 32'(bus.state), 4);
        check("err_ignore_valid", 32'(bus.slot_valid), 2'b11);
        pulse_clear();
        check("clr_state", 32'(bus.state), 0);
        check("clr_err", 32'(bus.err), 0);
        check("clr_valid", 32'(bus.slot_valid), 0);
        rd(1, 0, 0);
        check("clr_rd_invalid", 32'(bus.rd_data), 0);
        send_byte(8'd0);
        end_bytes();
        check("err0_state", 32'(bus.state), 4);
        pulse_clear();
        check("clr2_err", 32'(bus.err), 0);

        // clear coincident with final element: load discarded
        send_byte(8'd1); send_byte(8'd1);
        @(negedge clk);
        bus.rx_data = 8'd3; bus.rx_done = 1'b1; bus.clear = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0; bus.clear = 1'b0;
        check("clrlast_done", 32'(bus.load_done), 0);
        check("clrlast_valid", 32'(bus.slot_valid), 0);
        check("clrlast_state", 32'(bus.state), 0);

        // 1x1 completes on the third byte, into slot 0 after clear
        send_byte(8'd1); send_byte(8'd1);
        send_byte(8'd4);
        check("one_not_yet", 32'(bus.load_done), 0);
        end_bytes();
        check("one_done", 32'(bus.load_done), 1);
        check("one_slot", 32'(bus.load_slot), 0);

`ifdef MATRIX_RX_RANDGEN_EN
        // 5x5 generation -> slot 1, timed from the edge sampling gen_start
        @(negedge clk);
        bus.gen_m = 4'd5; bus.gen_n = 4'd5; bus.gen_start = 1'b1;
        @(negedge clk);
        bus.gen_start = 1'b0;
        k = 0;
        busy_cnt = 0;
        while (!bus.load_done && k < 100) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            k++;
        end
        check("gen_latency", 32'(k), 25);
        check("gen_busy", 32'(busy_cnt), 25);
        check("gen_slot", 32'(bus.load_slot), 1);
        lf = 8'h01;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                rd(1, r, c);
                check("gen_elem", 32'(bus.rd_data), 32'(lf % 8'd10));
                lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
            end
        end
        check("gen_rd_m", 32'(bus.rd_m), 5);
        @(negedge clk);
        bus.gen_m = 4'd6; bus.gen_n = 4'd2; bus.gen_start = 1'b1;
        @(negedge clk);
        bus.gen_start = 1'b0;
        check("gen_bad_dim", 32'(bus.state), 4);
        pulse_clear();
`else
        k = 0;
        busy_cnt = 0;
        lf = 8'h00;
        // Generation request must be ignored without the feature
        @(negedge clk);
        bus.gen_m = 4'd2; bus.gen_n = 4'd2; bus.gen_start = 1'b1;
        @(negedge clk);
        bus.gen_start = 1'b0;
        check("gen_ignored", 32'(bus.state), 0);
        check("gen_ignored_busy", 32'(bus.busy) + 32'(k) + 32'(busy_cnt) + 32'(lf), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_rx_loader.md
# matrix_rx_loader

Parametrised matrix input loader for the matrix calculator. It parses a byte stream from the UART receiver into dimension and element fields and stores complete matrices in a multi-slot buffer. It exposes a registered random-access read port for the calculation core and status for the LED/segment display. It sits between `uart_rx` and the compute datapath in `matrix_calc_top`.

## Interface
- `MAX_DIM`, 5, maximum rows/columns accepted (1..15)
- `ELEM_W`, 8, stored element width
- `ELEM_MAX`, 9, largest legal element value
- `SLOTS`, 2, number of matrix buffers (power of two, ≥1)
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-high
- `rx_data` in 8: received byte
- `rx_done` in 1: one-cycle strobe, `rx_data` valid
- `clear` in 1: one-cycle pulse; abort the current load and invalidate all slots
- `gen_start` in 1: start random generation (macro-dependent)
- `gen_m`, `gen_n` in 4: dimensions for generation
- `rd_slot` in clog2(SLOTS) (min 1): read slot select
- `rd_row`, `rd_col` in 4: read element select
- `rd_data` out ELEM_W: element read data, registered
- `rd_m`, `rd_n` out 4: dimensions of `rd_slot`, registered
- `slot_valid` out SLOTS: slot holds a complete matrix
- `load_done` out 1: one-cycle pulse when a matrix is complete
- `load_slot` out clog2(SLOTS): slot just completed; valid with `load_done`
- `clamped` out 1: at least one element of the last load was out of range
- `busy` out 1: high in `WAIT_N`, `LOAD` and `GEN`
- `err` out 1: sticky dimension error
- `state` out 3: current FSM state, for LEDs

## Operation
- States, with encodings: `IDLE`=0, `WAIT_N`=1, `LOAD`=2, `GEN`=3, `ERR`=4.
- `IDLE` + `rx_done`:
  - `rx_data` in 1..MAX_DIM: latch m, go to `WAIT_N`.
  - Otherwise: go to `ERR`.
- `WAIT_N` + `rx_done`:
  - `rx_data` in 1..MAX_DIM: latch n, clear row/col/`clamped`, go to `LOAD`.
  - Otherwise: go to `ERR`.
- `LOAD` + `rx_done`:
  - Write `rx_data` to slot `wr_ptr` at [row][col], row-major. Values > ELEM_MAX are stored as 0 and set `clamped`.
  - Advance col. On col==n-1, set col=0 and increment row.
  - On the last element (row==m-1, col==n-1):
    - store m and n for the slot;
    - set `slot_valid[wr_ptr]`;
    - pulse `load_done` with `load_slot`=`wr_ptr`;
    - advance `wr_ptr` modulo SLOTS;
    - go to `IDLE`.
- Slot overwrite: when all slots are valid, the next load overwrites slot `wr_ptr` (oldest first). That slot's valid bit clears when its `LOAD` begins.
- `ERR`: `err`=1. Bytes are ignored. Only `clear` or `rst` exits, to `IDLE`.
- `clear`, in any state:
  - go to `IDLE`;
  - `slot_valid`=0, `wr_ptr`=0, `err`=0;
  - any partial load is discarded.
- `gen_start` is honoured only in `IDLE`, and only with the macro (see Configuration).
- Read port:
  - `rd_data`, `rd_m` and `rd_n` update on the edge after the address is presented.
  - `rd_data`=0 when row ≥ m or col ≥ n of the slot, or when the slot is invalid.
  - A read and a write to the same cell in one cycle returns the old value.
- Element storage is SLOTS×MAX_DIM×MAX_DIM words of ELEM_W bits. Contents are undefined after reset; reads of invalid slots return 0 regardless.

## Timing
- Reset values: `state`=`IDLE`, `rd_data`=0, `rd_m`=0, `rd_n`=0, `slot_valid`=0, `load_done`=0, `load_slot`=0, `clamped`=0, `busy`=0, `err`=0, `wr_ptr`=0, LFSR=8'h01.
- Each `rx_done` is processed on the edge where it is sampled. The resulting state and outputs are visible the next cycle.
- `load_done` is high for exactly the cycle after the edge that sampled the final byte.
- Priority: `rst` > `clear` > `gen_start` > `rx_done`. An `rx_done` coincident with `clear` is dropped.
- Back-to-back `rx_done` on consecutive cycles are supported with no byte lost.
- A 1×1 matrix completes on the third byte.

## Configuration
- `MATRIX_RX_RANDGEN_EN` defined: random-generation mode (`GEN` state) is compiled in.
  - `gen_start` in `IDLE` with `gen_m` and `gen_n` both in 1..MAX_DIM latches the dimensions and enters `GEN`. Invalid dimensions go to `ERR`.
  - `GEN` writes one element per clock, equal to LFSR mod (ELEM_MAX+1), in row-major order.
  - The LFSR is 8-bit Fibonacci with taps 8,6,5,4 and steps every `GEN` cycle.
  - Completion is identical to `LOAD`. A generated m×n matrix asserts `load_done` m·n cycles after `gen_start` is sampled.
  - `rx_done` is ignored in `GEN`.
- Macro undefined: the `GEN` state and LFSR are absent and `gen_start`, `gen_m`, `gen_n` are ignored. The state encoding is unchanged.

## Test plan
- Bytes 2,3,1,2,3,4,5,6 → `load_done` pulse with `load_slot`=0 and `slot_valid`=01. Reading slot 0 gives rd_m=2, rd_n=3 and [1][2]=6; reading [2][0] gives 0.
- Dimension byte 7 or 0 in `IDLE` → `err`=1, `state`=4. Later bytes are ignored. After `clear`: `state`=0, `err`=0.
- Three loads with SLOTS=2 → third load goes to slot 0. `slot_valid[0]` drops at its n-byte and returns at completion. Slot 1 data is unchanged.
- Element byte 12 in a 1×1 load (bytes 1,1,12) → stored 0, `clamped`=1. The next load clears `clamped`.
- `clear` in the same cycle as the last element's `rx_done` → no `load_done`, `slot_valid`=0, `state`=`IDLE`.
- With the macro: `gen_start` with gen_m=5, gen_n=5 → `busy` for 25 cycles, then `load_done`. All elements are ≤ 9 and the sequence matches the LFSR reference model from seed 8'h01.
